// File: rtl/apx_float_mul_param.sv
// rtl/apx_float_mul_param.sv - parametrised approximate floating-point multiplier with runtime nab truncation
// Define APX_MUL_FTZ_EN to flush denormal operands and sub-normal results to signed zero.
module apx_float_mul_param #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int NAB_MAX = 16,
  parameter int NAB_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W+MAN_W:0]   input_a,
  input  logic                   input_a_stb,
  output logic                   input_a_ack,
  input  logic [NAB_W-1:0]       input_nab,
  input  logic [EXP_W+MAN_W:0]   input_b,
  input  logic                   input_b_stb,
  output logic                   input_b_ack,
  output logic [EXP_W+MAN_W:0]   output_z,
  output logic                   output_z_stb,
  input  logic                   output_z_ack
);

  localparam int W    = EXP_W + MAN_W + 1;
  localparam int M    = MAN_W + 1;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (2 ** (EXP_W - 1)) - 1;

  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] E_MIN  = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] E_ZFLD = EW'(-BIAS);
  localparam logic signed [EW-1:0] E_OFLD = EW'(BIAS + 1);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic [NAB_W-1:0]     NAB_LIM = NAB_W'(NAB_MAX);
  localparam logic [W-1:0]         QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, MULT_0,
    MULT_1, NORM_1, NORM_2, ROUND, PACK, PUT_Z
  } state_t;

  state_t                 state_q, state_d;
  logic                   a_ack_q, a_ack_d;
  logic                   b_ack_q, b_ack_d;
  logic                   z_stb_q, z_stb_d;
  logic [W-1:0]           z_q, z_d;
  logic [W-1:0]           a_q, a_d;
  logic [W-1:0]           b_q, b_d;
  logic [NAB_W-1:0]       nab_q, nab_d;
  logic                   a_s_q, a_s_d;
  logic                   b_s_q, b_s_d;
  logic                   z_s_q, z_s_d;
  logic [M-1:0]           a_m_q, a_m_d;
  logic [M-1:0]           b_m_q, b_m_d;
  logic [M-1:0]           z_m_q, z_m_d;
  logic signed [EW-1:0]   a_e_q, a_e_d;
  logic signed [EW-1:0]   b_e_q, b_e_d;
  logic signed [EW-1:0]   z_e_q, z_e_d;
  logic [2*M-1:0]         prod_q, prod_d;
  logic                   guard_q, guard_d;
  logic                   round_q, round_d;
  logic                   sticky_q, sticky_d;

  logic [MAN_W-1:0]       nab_mask;
  logic                   a_zfld, a_ofld, a_mz, a_zero;
  logic                   b_zfld, b_ofld, b_mz, b_zero;
  logic signed [EW-1:0]   z_e_inc, z_e_dec;
  logic [EXP_W-1:0]       z_exp_fld;
  logic [2*M-1:0]         prod_full;
  logic [M:0]             round_sum;
  logic                   round_up;

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z_stb = z_stb_q;
  assign output_z     = z_q;

  // Truncation mask: the low nab mantissa bits are discarded before any classification.
  assign nab_mask = {MAN_W{1'b1}} << nab_q;

  assign a_zfld = (a_e_q == E_ZFLD);
  assign a_ofld = (a_e_q == E_OFLD);
  assign a_mz   = (a_m_q[MAN_W-1:0] == '0);
  assign b_zfld = (b_e_q == E_ZFLD);
  assign b_ofld = (b_e_q == E_OFLD);
  assign b_mz   = (b_m_q[MAN_W-1:0] == '0);
`ifdef APX_MUL_FTZ_EN
  assign a_zero = a_zfld;
  assign b_zero = b_zfld;
`else
  assign a_zero = a_zfld && a_mz;
  assign b_zero = b_zfld && b_mz;
`endif

  assign z_e_inc   = z_e_q + E_ONE;
  assign z_e_dec   = z_e_q - E_ONE;
  assign z_exp_fld = EXP_W'(z_e_q + E_BIAS);
  assign prod_full = {{M{1'b0}}, a_m_q} * {{M{1'b0}}, b_m_q};
  assign round_sum = {1'b0, z_m_q} + {{M{1'b0}}, 1'b1};
  assign round_up  = guard_q && (round_q || sticky_q || z_m_q[0]);

  always_comb begin
    state_d  = state_q;
    a_ack_d  = a_ack_q;
    b_ack_d  = b_ack_q;
    z_stb_d  = z_stb_q;
    z_d      = z_q;
    a_d      = a_q;
    b_d      = b_q;
    nab_d    = nab_q;
    a_s_d    = a_s_q;
    b_s_d    = b_s_q;
    z_s_d    = z_s_q;
    a_m_d    = a_m_q;
    b_m_d    = b_m_q;
    z_m_d    = z_m_q;
    a_e_d    = a_e_q;
    b_e_d    = b_e_q;
    z_e_d    = z_e_q;
    prod_d   = prod_q;
    guard_d  = guard_q;
    round_d  = round_q;
    sticky_d = sticky_q;

    unique case (state_q)
      GET_A: begin
        a_ack_d = 1'b1;
        if (a_ack_q && input_a_stb) begin
          a_d     = input_a;
          nab_d   = (input_nab > NAB_LIM) ? NAB_LIM : input_nab;
          a_ack_d = 1'b0;
          state_d = GET_B;
        end
      end
      GET_B: begin
        b_ack_d = 1'b1;
        if (b_ack_q && input_b_stb) begin
          b_d     = input_b;
          b_ack_d = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        a_s_d   = a_q[W-1];
        b_s_d   = b_q[W-1];
        a_m_d   = {1'b0, a_q[MAN_W-1:0] & nab_mask};
        b_m_d   = {1'b0, b_q[MAN_W-1:0] & nab_mask};
        a_e_d   = $signed({2'b00, a_q[W-2 -: EXP_W]}) - E_BIAS;
        b_e_d   = $signed({2'b00, b_q[W-2 -: EXP_W]}) - E_BIAS;
        state_d = SPECIAL;
      end
      SPECIAL: begin
        z_s_d = a_s_q ^ b_s_q;
        if ((a_ofld && !a_mz) || (b_ofld && !b_mz) || (a_ofld && b_zero) || (b_ofld && a_zero)) begin
          z_d     = QNAN;
          z_stb_d = 1'b1;
          state_d = PUT_Z;
        end else if (a_ofld || b_ofld) begin
          z_d     = {a_s_q ^ b_s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          z_stb_d = 1'b1;
          state_d = PUT_Z;
        end else if (a_zero || b_zero) begin
          z_d     = {a_s_q ^ b_s_q, {(W-1){1'b0}}};
          z_stb_d = 1'b1;
          state_d = PUT_Z;
        end else begin
          if (a_zfld) a_e_d = E_MIN;
          else        a_m_d[MAN_W] = 1'b1;
          if (b_zfld) b_e_d = E_MIN;
          else        b_m_d[MAN_W] = 1'b1;
          if (a_zfld)      state_d = NORM_A;
          else if (b_zfld) state_d = NORM_B;
          else             state_d = MULT_0;
        end
      end
      // Leave on the cycle whose shift lands the hidden bit, so each shift costs one cycle.
      NORM_A: begin
        if (!a_m_q[MAN_W]) begin
          a_m_d = {a_m_q[MAN_W-1:0], 1'b0};
          a_e_d = a_e_q - E_ONE;
        end
        if (a_m_q[MAN_W] || a_m_q[MAN_W-1]) state_d = b_m_q[MAN_W] ? MULT_0 : NORM_B;
      end
      NORM_B: begin
        if (!b_m_q[MAN_W]) begin
          b_m_d = {b_m_q[MAN_W-1:0], 1'b0};
          b_e_d = b_e_q - E_ONE;
        end
        if (b_m_q[MAN_W] || b_m_q[MAN_W-1]) state_d = MULT_0;
      end
      MULT_0: begin
        prod_d  = prod_full;
        z_e_d   = a_e_q + b_e_q + E_ONE;
        state_d = MULT_1;
      end
      MULT_1: begin
        z_m_d    = prod_q[2*M-1 -: M];
        guard_d  = prod_q[M-1];
        round_d  = prod_q[M-2];
        sticky_d = |prod_q[M-3:0];
        state_d  = NORM_1;
      end
      NORM_1: begin
        if (!z_m_q[MAN_W] && (z_e_q > E_MIN)) begin
          z_m_d   = {z_m_q[MAN_W-1:0], guard_q};
          z_e_d   = z_e_dec;
          guard_d = round_q;
          round_d = 1'b0;
          if (z_m_q[MAN_W-1] || (z_e_dec == E_MIN)) state_d = ROUND;
        end else if (z_e_q < E_MIN) begin
`ifdef APX_MUL_FTZ_EN
          state_d = ROUND;
`else
          state_d = NORM_2;
`endif
        end else begin
          state_d = ROUND;
        end
      end
      NORM_2: begin
        z_e_d    = z_e_inc;
        z_m_d    = {1'b0, z_m_q[MAN_W:1]};
        guard_d  = z_m_q[0];
        round_d  = guard_q;
        sticky_d = sticky_q || round_q;
        if (z_e_inc >= E_MIN) state_d = ROUND;
      end
      ROUND: begin
        if (round_up) begin
          if (round_sum[M]) begin
            z_m_d = {1'b1, {MAN_W{1'b0}}};
            z_e_d = z_e_inc;
          end else begin
            z_m_d = round_sum[M-1:0];
          end
        end
        state_d = PACK;
      end
      PACK: begin
        z_d = {z_s_q, z_exp_fld, z_m_q[MAN_W-1:0]};
`ifdef APX_MUL_FTZ_EN
        if (!z_m_q[MAN_W] || (z_e_q < E_MIN)) z_d = {z_s_q, {(W-1){1'b0}}};
`else
        if (!z_m_q[MAN_W]) z_d = {z_s_q, {EXP_W{1'b0}}, z_m_q[MAN_W-1:0]};
`endif
        if (z_e_q > E_BIAS) z_d = {z_s_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        z_stb_d = 1'b1;
        state_d = PUT_Z;
      end
      PUT_Z: begin
        if (output_z_ack) begin
          z_stb_d = 1'b0;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= GET_A;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      z_stb_q  <= 1'b0;
      z_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      nab_q    <= '0;
      a_s_q    <= 1'b0;
      b_s_q    <= 1'b0;
      z_s_q    <= 1'b0;
      a_m_q    <= '0;
      b_m_q    <= '0;
      z_m_q    <= '0;
      a_e_q    <= '0;
      b_e_q    <= '0;
      z_e_q    <= '0;
      prod_q   <= '0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      z_stb_q  <= z_stb_d;
      z_q      <= z_d;
      a_q      <= a_d;
      b_q      <= b_d;
      nab_q    <= nab_d;
      a_s_q    <= a_s_d;
      b_s_q    <= b_s_d;
      z_s_q    <= z_s_d;
      a_m_q    <= a_m_d;
      b_m_q    <= b_m_d;
      z_m_q    <= z_m_d;
      a_e_q    <= a_e_d;
      b_e_q    <= b_e_d;
      z_e_q    <= z_e_d;
      prod_q   <= prod_d;
      guard_q  <= guard_d;
      round_q  <= round_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_apx_float_mul_param.sv
// tb/tb_apx_float_mul_param.sv - directed bench for apx_float_mul_param (single and half formats)
// Expected values for APX_MUL_FTZ_EN builds are selected by the same macro.
module tb_apx_float_mul_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fa, fb, fz;
  logic        fa_stb, fa_ack, fb_stb, fb_ack, fz_stb, fz_ack;
  logic [4:0]  fnab;
  logic [15:0] ha, hb, hz;
  logic        ha_stb, ha_ack, hb_stb, hb_ack, hz_stb, hz_ack;
  logic [4:0]  hnab;

  int checks = 0;
  int failures = 0;

`ifdef APX_MUL_FTZ_EN
  localparam logic [31:0] UF_EXP  = 32'h00000000;
  localparam logic [31:0] DEN_EXP = 32'h00000000;
  localparam int          DEN_LAT = 2;
`else
  localparam logic [31:0] UF_EXP  = 32'h00400000;
  localparam logic [31:0] DEN_EXP = 32'h00000001;
  localparam int          DEN_LAT = 52;
`endif

  always #5 clk = ~clk;

  apx_float_mul_param dut (
    .clk(clk), .rst(rst),
    .input_a(fa), .input_a_stb(fa_stb), .input_a_ack(fa_ack), .input_nab(fnab),
    .input_b(fb), .input_b_stb(fb_stb), .input_b_ack(fb_ack),
    .output_z(fz), .output_z_stb(fz_stb), .output_z_ack(fz_ack)
  );

  apx_float_mul_param #(.EXP_W(5), .MAN_W(10), .NAB_MAX(4), .NAB_W(5)) dut_h (
    .clk(clk), .rst(rst),
    .input_a(ha), .input_a_stb(ha_stb), .input_a_ack(ha_ack), .input_nab(hnab),
    .input_b(hb), .input_b_stb(hb_stb), .input_b_ack(hb_ack),
    .output_z(hz), .output_z_stb(hz_stb), .output_z_ack(hz_ack)
  );

  task automatic send(input bit h, input bit is_b, input logic [31:0] v, input logic [4:0] n, output bit to);
    if (h) begin
      if (is_b) begin hb = v[15:0]; hb_stb = 1'b1; end
      else begin ha = v[15:0]; hnab = n; ha_stb = 1'b1; end
    end else begin
      if (is_b) begin fb = v; fb_stb = 1'b1; end
      else begin fa = v; fnab = n; fa_stb = 1'b1; end
    end
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (h ? (is_b ? hb_ack : ha_ack) : (is_b ? fb_ack : fa_ack)) begin
        to = 1'b0;
        break;
      end
    end
    if (!to) begin
      @(posedge clk);
      #1;
    end
    fa_stb = 1'b0; fb_stb = 1'b0; ha_stb = 1'b0; hb_stb = 1'b0;
  endtask

  task automatic wait_z(input bit h, output int lat, output bit to);
    lat = 0;
    to  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (h ? hz_stb : fz_stb) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic accept_z(input bit h);
    if (h) hz_ack = 1'b1;
    else   fz_ack = 1'b1;
    @(posedge clk);
    #1;
    hz_ack = 1'b0;
    fz_ack = 1'b0;
  endtask

  task automatic run_op(input bit h, input logic [31:0] a, input logic [31:0] b, input logic [4:0] n,
                        output logic [31:0] z, output int lat, output bit to);
    bit t1, t2, t3;
    z = '0;
    lat = 0;
    send(h, 1'b0, a, n, t1);
    send(h, 1'b1, b, 5'd0, t2);
    if (t1 || t2) begin
      to = 1'b1;
      return;
    end
    wait_z(h, lat, t3);
    z = h ? {16'h0000, hz} : fz;
    if (!t3) accept_z(h);
    to = t3;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({fa_ack, fb_ack, fz_stb, fz} !== 35'd0) begin
      failures++;
      $display("FAIL reset_single got acks/stb/z=%b%b%b/%h required 000/00000000", fa_ack, fb_ack, fz_stb, fz);
    end
    checks++;
    if ({ha_ack, hb_ack, hz_stb, hz} !== 19'd0) begin
      failures++;
      $display("FAIL reset_half got acks/stb/z=%b%b%b/%h required 000/0000", ha_ack, hb_ack, hz_stb, hz);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (fa_ack !== 1'b1 || fb_ack !== 1'b0) begin
      failures++;
      $display("FAIL ack_rise got a_ack=%b b_ack=%b required a_ack=1 b_ack=0", fa_ack, fb_ack);
    end
  endtask

  task automatic test_basic();
    logic [31:0] z; int lat; bit to;
    run_op(1'b0, 32'h40000000, 32'h40400000, 5'd0, z, lat, to);
    checks++;
    if (to || z !== 32'h40C00000) begin
      failures++;
      $display("FAIL mul_2x3 got=%h timeout=%0d required=40c00000", z, to);
    end
    checks++;
    if (lat !== 7) begin
      failures++;
      $display("FAIL latency_normal got=%0d required=7", lat);
    end
  endtask

  task automatic test_nab();
    logic [31:0] va [5] = '{32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F810000, 32'h3F810000};
    logic [4:0]  vn [5] = '{5'd0, 5'd1, 5'd31, 5'd31, 5'd17};
    logic [31:0] ve [5] = '{32'h3F800002, 32'h3F800000, 32'h3F800000, 32'h3F810000, 32'h3F810000};
    logic [31:0] vb [5] = '{32'h3F800001, 32'h3F800001, 32'h3F800001, 32'h3F800000, 32'h3F800000};
    logic [31:0] z; int lat; bit to;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, va[i], vb[i], vn[i], z, lat, to);
      checks++;
      if (to || z !== ve[i]) begin
        failures++;
        $display("FAIL nab_vec%0d nab=%0d got=%h timeout=%0d required=%h", i, vn[i], z, to, ve[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] va [4] = '{32'h7F800000, 32'hFF800000, 32'h80000000, 32'h7FC00001};
    logic [31:0] vb [4] = '{32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000};
    logic [31:0] ve [4] = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h7FC00000};
    logic [31:0] z; int lat; bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, va[i], vb[i], 5'd0, z, lat, to);
      checks++;
      if (to || z !== ve[i]) begin
        failures++;
        $display("FAIL special_vec%0d got=%h timeout=%0d required=%h", i, z, to, ve[i]);
      end
      checks++;
      if (lat !== 2) begin
        failures++;
        $display("FAIL special_latency%0d got=%0d required=2", i, lat);
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] z; int lat; bit to;
    run_op(1'b0, 32'h7F000000, 32'h40000000, 5'd0, z, lat, to);
    checks++;
    if (to || z !== 32'h7F800000) begin
      failures++;
      $display("FAIL overflow got=%h timeout=%0d required=7f800000", z, to);
    end
    run_op(1'b0, 32'h00800000, 32'h3F000000, 5'd0, z, lat, to);
    checks++;
    if (to || z !== UF_EXP) begin
      failures++;
      $display("FAIL underflow got=%h timeout=%0d required=%h", z, to, UF_EXP);
    end
    run_op(1'b0, 32'h00000001, 32'h3F800000, 5'd0, z, lat, to);
    checks++;
    if (to || z !== DEN_EXP) begin
      failures++;
      $display("FAIL denorm_in got=%h timeout=%0d required=%h", z, to, DEN_EXP);
    end
    checks++;
    if (lat !== DEN_LAT) begin
      failures++;
      $display("FAIL denorm_latency got=%0d required=%0d", lat, DEN_LAT);
    end
  endtask

  task automatic test_half();
    logic [15:0] va [4] = '{16'h3C00, 16'h3C01, 16'h3C01, 16'h3C10};
    logic [15:0] vb [4] = '{16'h4000, 16'h3C01, 16'h3C01, 16'h3C00};
    logic [4:0]  vn [4] = '{5'd0, 5'd1, 5'd0, 5'd7};
    logic [15:0] ve [4] = '{16'h4000, 16'h3C00, 16'h3C02, 16'h3C10};
    logic [31:0] z; int lat; bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, {16'h0000, va[i]}, {16'h0000, vb[i]}, vn[i], z, lat, to);
      checks++;
      if (to || z[15:0] !== ve[i]) begin
        failures++;
        $display("FAIL half_vec%0d got=%h timeout=%0d required=%h", i, z[15:0], to, ve[i]);
      end
    end
  endtask

  task automatic test_stall();
    bit t1, t2, t3; int lat;
    send(1'b0, 1'b0, 32'h3F800001, 5'd0, t1);
    send(1'b0, 1'b1, 32'h3F800001, 5'd0, t2);
    wait_z(1'b0, lat, t3);
    checks++;
    if (t1 || t2 || t3) begin
      failures++;
      $display("FAIL stall_setup timeout a=%0d b=%0d z=%0d required none", t1, t2, t3);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (fz_stb !== 1'b1 || fz !== 32'h3F800002) begin
        failures++;
        $display("FAIL stall_hold cycle%0d got stb=%b z=%h required stb=1 z=3f800002", i, fz_stb, fz);
      end
    end
    accept_z(1'b0);
    checks++;
    if (fz_stb !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got stb=%b required 0", fz_stb);
    end
  endtask

  task automatic test_reset_midop();
    bit t1, t2; logic [31:0] z; int lat; bit to;
    send(1'b0, 1'b0, 32'h40000000, 5'd0, t1);
    send(1'b0, 1'b1, 32'h40400000, 5'd0, t2);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (t1 || t2 || {fa_ack, fb_ack, fz_stb} !== 3'b000 || fz !== 32'h0 || hz !== 16'h0) begin
      failures++;
      $display("FAIL reset_midop got acks/stb=%b%b%b z=%h hz=%h required 000 z=0 hz=0", fa_ack, fb_ack, fz_stb, fz, hz);
    end
    @(negedge clk);
    rst = 1'b0;
    run_op(1'b0, 32'h3F800001, 32'h3F800001, 5'd0, z, lat, to);
    checks++;
    if (to || z !== 32'h3F800002 || lat !== 7) begin
      failures++;
      $display("FAIL after_reset got=%h lat=%0d timeout=%0d required=3f800002 lat=7", z, lat, to);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] z1, z2; int l1, l2; bit to1, to2;
    run_op(1'b0, 32'hC0000000, 32'h40400000, 5'd0, z1, l1, to1);
    run_op(1'b0, 32'h3FC00000, 32'h3FC00000, 5'd0, z2, l2, to2);
    checks++;
    if (to1 || z1 !== 32'hC0C00000) begin
      failures++;
      $display("FAIL b2b_first got=%h timeout=%0d required=c0c00000", z1, to1);
    end
    checks++;
    if (to2 || z2 !== 32'h40100000 || l2 !== 7) begin
      failures++;
      $display("FAIL b2b_second got=%h lat=%0d timeout=%0d required=40100000 lat=7", z2, l2, to2);
    end
  endtask

  initial begin
    rst = 1'b1;
    fa = '0; fb = '0; fnab = '0; fa_stb = 1'b0; fb_stb = 1'b0; fz_ack = 1'b0;
    ha = '0; hb = '0; hnab = '0; ha_stb = 1'b0; hb_stb = 1'b0; hz_ack = 1'b0;
    test_reset();
    test_basic();
    test_nab();
    test_special();
    test_range();
    test_half();
    test_stall();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apx_float_mul_param.md
Name: apx_float_mul_param

Overview:
- Parametrised successor to the fixed-format approximate FP multiplier. Exponent and mantissa widths are generic; half, single and custom formats all come from one RTL.
- Approximation level (number of truncated mantissa LSBs, "nab") is selectable at runtime per operation, not at elaboration.
- Sits on the same stb/ack operand/result streams as the other float_ops_apx blocks. Adds full IEEE special-case handling, denormals and round-to-nearest-even.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored mantissa field width
NAB_MAX, 16, maximum approximate bits; must satisfy NAB_MAX <= MAN_W
NAB_W, 5, width of input_nab; 2^NAB_W-1 >= NAB_MAX

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
input_a  in  EXP_W+MAN_W+1  operand A
input_a_stb  in  1  A valid
input_a_ack  out  1  A ready
input_nab  in  NAB_W  approximate-bit count, sampled with A
input_b  in  EXP_W+MAN_W+1  operand B
input_b_stb  in  1  B valid
input_b_ack  out  1  B ready
output_z  out  EXP_W+MAN_W+1  product
output_z_stb  out  1  Z valid
output_z_ack  in  1  Z accepted

Behaviour:
- Reset (async, any state): state=GET_A; input_a_ack, input_b_ack, output_z_stb = 0; output_z = 0. Any in-flight operation is discarded.
- Handshake, A: ack rises one cycle after entering GET_A. Transfer happens on a clock edge with ack&&stb both high; ack drops on that edge. B uses the same rule.
- Handshake, Z: output_z_stb rises on entry to PUT_Z and holds, with output_z stable, until a cycle with stb&&output_z_ack. stb then clears and the FSM returns to GET_A.
- nab handling: input_nab is latched on the A transfer. Values > NAB_MAX are clamped to NAB_MAX.
- States: GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, MULT_0, MULT_1, NORM_1, NORM_2, ROUND, PACK, PUT_Z.
- UNPACK: split sign, exponent and mantissa. The low nab mantissa bits of both operands are forced to 0 (this is the approximation). Exponents are unbiased into signed EXP_W+2-bit registers.
- SPECIAL, evaluated after masking:
  - NaN in, or inf*0 -> canonical quiet NaN (sign 0, exp all-ones, MSB of mantissa 1, rest 0).
  - inf*finite-nonzero -> inf with sign a_s^b_s.
  - zero*finite -> signed zero.
  - A masked denormal that becomes all-zero counts as zero.
  - Special results go straight to PUT_Z.
  - Otherwise: denormals get exponent 1-bias; normals get the hidden bit set.
- NORM_A / NORM_B: shift left one bit per cycle until the hidden bit is set.
- MULT_0: single-cycle (MAN_W+1)x(MAN_W+1) full product; z_e = a_e+b_e+1.
- MULT_1: split the product into z_m (MAN_W+1 bits), guard, round and sticky.
- NORM_1: at most one left shift per cycle, pulling guard into the LSB.
- NORM_2: while z_e < 1-bias, shift right, accumulating sticky.
- ROUND: round-to-nearest-even. A mantissa carry-out increments z_e and renormalises.
- PACK:
  - z_e > bias -> signed inf.
  - Denormal result (hidden bit 0 at minimum exponent) -> exponent field 0.
- Latency: 7 cycles from the B transfer to stb for normal operands. Add 1 cycle per normalisation shift. Special cases take 2 cycles.
- Holding stimulus: stb held high while ack is low has no effect. Back-to-back operations need no idle cycle beyond the GET_A ack rise.

Optional Feature:
- Macro APX_MUL_FTZ_EN.
- When defined:
  - Denormal inputs are treated as signed zero in SPECIAL.
  - Results below the minimum normal are flushed to signed zero.
  - NORM_A, NORM_B and NORM_2 are never entered with a denormal, giving a fixed 7-cycle latency.
- When undefined: gradual underflow exactly as in Behaviour.

Test Plan (default params unless stated):
- 0x40000000 * 0x40400000, nab=0 -> 0x40C00000; latency exactly 7 cycles.
- 0x3F800001 * 0x3F800001: nab=0 -> 0x3F800002; nab=1 -> 0x3F800000; nab=31 clamped to 16 -> 0x3F800000.
- 0x7F800000 * 0x00000000 -> 0x7FC00000; 0xFF800000 * 0x40000000 -> 0xFF800000; 0x80000000 * 0x3F800000 -> 0x80000000.
- 0x7F000000 * 0x40000000 -> overflow 0x7F800000. 0x00800000 * 0x3F000000 -> 0x00400000, or 0x00000000 with APX_MUL_FTZ_EN.
- output_z_ack held low 20 cycles -> output_z and stb stable throughout. Assert rst in MULT_1 -> all acks and stb 0 immediately; the next operation completes correctly.
- EXP_W=5, MAN_W=10, NAB_MAX=4: 0x3C00 * 0x4000 -> 0x4000; 0x3C01 * 0x3C01 with nab=1 -> 0x3C00.
